// File: rtl/ifetch_bpred_pkg.sv
// Shared opcodes, counter encodings, IQ entry layout and RV32 immediate decode
// for the fetch / branch-prediction stage.
package ifetch_bpred_pkg;

  localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR = 7'b1100111;
  localparam logic [6:0] OPCODE_SB   = 7'b1100011;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] alt_pc;
  } iq_entry_t;

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic cnt_t cnt_next(input cnt_t c, input logic taken);
    if (taken) return (c == CNT_ST) ? c : c + 2'd1;
    return (c == CNT_SNT) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/ifetch_bpred_if.sv
// Fetch-stage bundle: ICache request/response, Decoder handoff and backend
// commit/flush. master = fetch stage, slave = surrounding pipeline.
interface ifetch_bpred_if;
  logic [31:0] fetch_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic        fetch_stall;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_pred_taken;
  logic [31:0] dec_alt_pc;
  logic        dec_ready;
  logic        br_commit;
  logic        br_taken;
  logic        flush;
  logic [31:0] flush_pc;

  modport master (
    output fetch_pc, fetch_stall, dec_valid, dec_instr, dec_pc,
           dec_pred_taken, dec_alt_pc,
    input  instr_valid, instr, dec_ready, br_commit, br_taken, flush, flush_pc
  );

  modport slave (
    input  fetch_pc, fetch_stall, dec_valid, dec_instr, dec_pc,
           dec_pred_taken, dec_alt_pc,
    output instr_valid, instr, dec_ready, br_commit, br_taken, flush, flush_pc
  );
endinterface

// File: rtl/ifetch_bpred_sync_fifo.sv
// Generic synchronous FIFO with pointer/count clear on flush.
// Latency: push visible at pop_dat next cycle, no bypass.
// Backpressure: push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [1 << AW];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  // count never exceeds the depth, so its MSB alone marks full
  assign full    = count[AW];
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ifetch_bpred.sv
// Instruction fetch with 2-bit BHT prediction, in-flight branch queue and IQ.
// Latency: accepted word reaches dec_* next cycle; BHT training visible next cycle.
// Backpressure: fetch_stall when IQ full, BQ full on a branch, flush, or rdy low.
module ifetch_bpred import ifetch_bpred_pkg::*; #(
  parameter int          BHT_IDX_W = 12,
  parameter int          BQ_AW     = 4,
  parameter int          IQ_AW     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter cnt_t        CNT_INIT  = CNT_WNT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  ifetch_bpred_if.master bus
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [31:0]          pc_q;
  cnt_t                 bht [BHT_N];
  logic [6:0]           opc;
  logic                 is_jal;
  logic                 is_sb;
  logic                 pred_taken;
  logic                 accept;
  logic [BHT_IDX_W-1:0] idx;
  logic [BHT_IDX_W-1:0] bq_head;
  logic [31:0]          imm;
  logic [31:0]          target;
  logic [31:0]          seq_pc;
  logic [31:0]          next_pc;
  logic [31:0]          alt_pc;
  iq_entry_t            iq_push_dat;
  iq_entry_t            iq_head;
  logic                 iq_empty;
  logic                 iq_full;
  logic                 bq_empty;
  logic                 bq_full;
  logic                 q_flush;
  logic                 iq_pop;
  logic                 bq_pop;

  assign opc        = bus.instr[6:0];
  assign is_jal     = (opc == OPCODE_JAL);
  assign is_sb      = (opc == OPCODE_SB);
  assign idx        = pc_q[BHT_IDX_W+1:2];
  assign pred_taken = is_sb && (bht[idx] >= CNT_WT);
  assign imm        = is_jal ? imm_j(bus.instr) : imm_b(bus.instr);
  assign target     = pc_q + imm;
  assign seq_pc     = pc_q + 32'd4;
  // JALR and everything else fall through; the backend redirects via flush
  assign next_pc    = (is_jal || pred_taken) ? target : seq_pc;
  assign alt_pc     = (is_sb && !pred_taken) ? target : seq_pc;

  assign accept = rdy && bus.instr_valid && !bus.flush && !iq_full
                  && !(is_sb && bq_full);
  assign bus.fetch_stall = bus.instr_valid && !accept;

  assign q_flush = rdy && bus.flush;
  assign iq_pop  = rdy && bus.dec_ready && !bus.flush;
  assign bq_pop  = rdy && bus.br_commit && !bq_empty;

  assign iq_push_dat = '{instr: bus.instr, pc: pc_q, pred_taken: pred_taken, alt_pc: alt_pc};

  sync_fifo #(.WIDTH($bits(iq_entry_t)), .AW(IQ_AW)) u_iq (
    .clk      (clk),
    .rst      (rst),
    .flush    (q_flush),
    .push     (accept),
    .push_dat (iq_push_dat),
    .pop      (iq_pop),
    .pop_dat  (iq_head),
    .empty    (iq_empty),
    .full     (iq_full)
  );

  sync_fifo #(.WIDTH(BHT_IDX_W), .AW(BQ_AW)) u_bq (
    .clk      (clk),
    .rst      (rst),
    .flush    (q_flush),
    .push     (accept && is_sb),
    .push_dat (idx),
    .pop      (bq_pop),
    .pop_dat  (bq_head),
    .empty    (bq_empty),
    .full     (bq_full)
  );

  assign bus.fetch_pc       = pc_q;
  assign bus.dec_valid      = !iq_empty;
  assign bus.dec_instr      = iq_empty ? '0 : iq_head.instr;
  assign bus.dec_pc         = iq_empty ? '0 : iq_head.pc;
  assign bus.dec_pred_taken = !iq_empty && iq_head.pred_taken;
  assign bus.dec_alt_pc     = iq_empty ? '0 : iq_head.alt_pc;

  always_ff @(posedge clk) begin
    if (rst)                    pc_q <= RESET_PC;
    else if (rdy && bus.flush)  pc_q <= bus.flush_pc;
    else if (accept)            pc_q <= next_pc;
  end

  // Training happens even on a flush cycle; the flush only clears the queues
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= CNT_INIT;
    end else if (bq_pop) begin
      bht[bq_head] <= cnt_next(bht[bq_head], bus.br_taken);
    end
  end

endmodule
